serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. It reuses a single full-adder bit cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. A carry flip-flop closes the loop between bits. It is the area-minimal alternative to a ripple array and takes a start/busy/done handshake from the surrounding control logic.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start
b  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle completion pulse
sum  output  WIDTH  result register
cout  output  1  final carry-out register

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. Reset forces all flops to zero: state=IDLE, busy=0, done=0, sum=0, cout=0, shift registers, carry flop and bit counter.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - When start=1: load shreg_a<=a, shreg_b<=b, carry<=cin, cnt<=0, go to RUN.
- RUN:
  - busy=1.
  - Each cycle the bit cell adds shreg_a[0], shreg_b[0] and carry.
  - shreg_a and shreg_b shift right by one.
  - The sum bit shifts into the MSB of shreg_s.
  - carry takes the cell carry-out.
  - cnt increments.
  - When cnt==WIDTH-1: copy the final shreg_s into sum, copy the cell carry-out into cout, set done<=1, go to DONE.
- DONE:
  - busy=0, done=1 for exactly this cycle.
  - Unconditionally go to IDLE.
- Latency: with start sampled at edge k, done is high during the cycle after edge k+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while in RUN or DONE is ignored. It is not queued.
- Operand changes after the accepted start have no effect.
- sum and cout keep the last result until the next completion.
  - They do not change during RUN.
  - They are not cleared by a new start.
- cnt width is clog2(WIDTH). The counter never wraps inside a transaction.
- Reset mid-RUN aborts the transaction immediately. No done pulse is produced. Outputs return to their reset values.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured on the accepted start.
  - With sub=1: shreg_b loads ~b and the carry flop loads 1 (cin is ignored). The result is a-b mod 2^WIDTH; cout=1 means no borrow.
  - With sub=0: behaviour is identical to the base block.
- Undefined: the sub port does not exist and the block is add-only.

Decomposition:
- Shared package or header: FSM state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the clog2 helper function.
- One sub-module, fa_bit: combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once.
- All sequencing, shift registers and the carry flop stay in serial_adder_ctrl.

Test Plan (WIDTH=8 unless noted):
- a=0x35, b=0x4A, cin=0, start pulse -> busy for 8 cycles, done one cycle, sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- start held high continuously from IDLE -> back-to-back transactions, each with exactly one done pulse and spacing WIDTH+2; start in RUN/DONE starts nothing.
- Change a/b mid-RUN (a=0x12, b=0x34 accepted, then drive 0xFF/0xFF) -> sum=0x46, cout=0.
- rst_n low at the 3rd RUN cycle -> busy, done, sum and cout go to 0 asynchronously, no done pulse; next start with a=0x01, b=0x01 -> sum=0x02.
- SERIAL_ADDER_SUB_EN, sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1. Then a=0x01, b=0x02 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and a width helper.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of bits needed to count 0..value-1; callers clamp the result to >= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle of the bit-serial adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  // start is sampled only while the sequencer is idle; a start seen during
  // RUN or DONE is dropped, not queued. done pulses for one cycle per result,
  // and sum/cout are valid from that cycle until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start,
    output a,
    output b,
    output cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy,
    input  done,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy,
    output done,
    output sum,
    output cout
  );

endinterface

// File: rtl/fa_bit.sv
// Single combinational full-adder cell reused every cycle by the serial sequencer.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (a - b via ~b and carry-in 1).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shreg_a_q, shreg_a_d;
  logic [WIDTH-1:0] shreg_b_q, shreg_b_d;
  logic [WIDTH-1:0] shreg_s_q, shreg_s_d;
  logic             carry_q,   carry_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             cout_q,    cout_d;
  logic             done_q,    done_d;

  logic fa_s;
  logic fa_c;

  fa_bit u_fa_bit (
    .a    (shreg_a_q[0]),
    .b    (shreg_b_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_a_d = shreg_a_q;
    shreg_b_d = shreg_b_q;
    shreg_s_d = shreg_s_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_a_d = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          shreg_b_d = bus.sub ? ~bus.b : bus.b;
          carry_d   = bus.sub ? 1'b1 : bus.cin;
`else
          shreg_b_d = bus.b;
          carry_d   = bus.cin;
`endif
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        shreg_a_d = {1'b0, shreg_a_q[WIDTH-1:1]};
        shreg_b_d = {1'b0, shreg_b_q[WIDTH-1:1]};
        shreg_s_d = {fa_s, shreg_s_q[WIDTH-1:1]};
        carry_d   = fa_c;
        // On the last bit the counter holds so it never wraps mid-transaction.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, shreg_s_q[WIDTH-1:1]};
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_a_q <= '0;
      shreg_b_q <= '0;
      shreg_s_q <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_a_q <= shreg_a_d;
      shreg_b_q <= shreg_b_d;
      shreg_s_q <= shreg_s_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign dbg_state = state_q;

endmodule
